// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Holds the FSM state enum, base opcodes, ALU operation codes, the
// PC_s / w_data_s / Size_s select encodings and the store byte-mask helper.
package riscv_mc_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_BR   = 3'd5,
      S_JMP  = 3'd6,
      S_HALT = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic [1:0] PCS_PC4 = 2'd0;
   localparam logic [1:0] PCS_IMM = 2'd1;
   localparam logic [1:0] PCS_F   = 2'd2;

   localparam logic [2:0] WDS_F     = 3'd0;
   localparam logic [2:0] WDS_IMM   = 3'd1;
   localparam logic [2:0] WDS_MDR   = 3'd2;
   localparam logic [2:0] WDS_PC    = 3'd3;
   localparam logic [2:0] WDS_PCIMM = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Byte-lane write enables for a store of the given access size.
   function automatic logic [3:0] store_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: store_mask = 4'b0001;
         SZ_HALF: store_mask = 4'b0011;
         SZ_WORD: store_mask = 4'b1111;
         default: store_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_ctrl_branch_cond.sv
// Branch condition evaluation from func3 and the registered ALU flags.
// Ports: func3 (branch kind), zf/sf/cf/of (flags from a SUB), taken (result).
module branch_cond (
   input  logic [2:0] func3,
   input  logic       zf,
   input  logic       sf,
   input  logic       cf,
   input  logic       of,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (func3)
         3'b000:  taken = zf;
         3'b001:  taken = ~zf;
         3'b100:  taken = sf ^ of;
         3'b101:  taken = ~(sf ^ of);
         3'b110:  taken = cf;
         3'b111:  taken = ~cf;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM.
// Inputs: clk, rst_ (sync active-low), opcode/func3/func7 from IR, ZF/SF/CF/OF flags.
// Outputs: ALU_OP, write enables (PC, PC0, IR, Reg, Mem), datapath selects
// (SE_s, Size_s, PC_s, rs2_imm_s, w_data_s), store byte lanes st, halted, instr_done.
//
// state | meaning
// IF    | fetch: load IR, save PC into PC0, PC <= PC+4
// ID    | decode and dispatch on opcode
// EX    | ALU operation for R/I/LOAD/STORE/BRANCH/JALR
// MEM   | memory access (store retires here)
// WB    | register write-back
// BR    | conditional PC update from flags
// JMP   | link register write plus PC redirect
// HALT  | illegal opcode, frozen until reset
module riscv_mc_ctrl
   import riscv_mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       ZF,
   input  logic       SF,
   input  logic       CF,
   input  logic       OF,
   output logic [3:0] ALU_OP,
   output logic       PC_Write,
   output logic       PC0_Write,
   output logic       IR_Write,
   output logic       Reg_Write,
   output logic       Mem_write,
   output logic       SE_s,
   output logic [1:0] Size_s,
   output logic [1:0] PC_s,
   output logic       rs2_imm_s,
   output logic [2:0] w_data_s,
   output logic [3:0] st,
   output logic       halted,
   output logic       instr_done
);

   state_t state, state_nxt;
   logic   taken;
   logic   is_r, is_i, is_ld, is_st, is_br, is_jalr, is_jal, is_lui, is_auipc;
   logic   unused_func7;

   assign unused_func7 = ^{func7[6], func7[4:0]};

   assign is_r     = (opcode == OP_R);
   assign is_i     = (opcode == OP_I);
   assign is_ld    = (opcode == OP_LOAD);
   assign is_st    = (opcode == OP_STORE);
   assign is_br    = (opcode == OP_BRANCH);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_jal   = (opcode == OP_JAL);
   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);

   branch_cond u_branch_cond (
      .func3 (func3),
      .zf    (ZF),
      .sf    (SF),
      .cf    (CF),
      .of    (OF),
      .taken (taken)
   );

   always_ff @(posedge clk) begin
      if (!rst_) state <= S_IF;
      else       state <= state_nxt;
   end

   // All outputs are forced to zero while reset is low so an aborted
   // instruction cannot issue any write in the reset cycle.
   always_comb begin
      state_nxt  = state;
      ALU_OP     = ALU_ADD;
      PC_Write   = 1'b0;
      PC0_Write  = 1'b0;
      IR_Write   = 1'b0;
      Reg_Write  = 1'b0;
      Mem_write  = 1'b0;
      SE_s       = 1'b0;
      Size_s     = SZ_BYTE;
      PC_s       = PCS_PC4;
      rs2_imm_s  = 1'b0;
      w_data_s   = WDS_F;
      st         = 4'b0000;
      halted     = 1'b0;
      instr_done = 1'b0;

      if (rst_) begin
         // Shift ops (func3=101) carry the arithmetic/logical bit in func7[5].
         if (is_r || (is_i && func3 == 3'b101)) ALU_OP = {func7[5], func3};
         else if (is_i)                         ALU_OP = {1'b0, func3};
         else if (is_br)                        ALU_OP = ALU_SUB;
         rs2_imm_s = is_i | is_ld | is_st | is_jalr;

         case (state)
            S_IF: begin
               IR_Write  = 1'b1;
               PC0_Write = 1'b1;
               PC_Write  = 1'b1;
               PC_s      = PCS_PC4;
               state_nxt = S_ID;
            end
            S_ID: begin
               if (is_r || is_i || is_ld || is_st || is_br || is_jalr) state_nxt = S_EX;
               else if (is_jal)                                       state_nxt = S_JMP;
               else if (is_lui || is_auipc)                           state_nxt = S_WB;
               else                                                   state_nxt = S_HALT;
            end
            S_EX: begin
               if (is_r || is_i)       state_nxt = S_WB;
               else if (is_ld || is_st) state_nxt = S_MEM;
               else if (is_br)          state_nxt = S_BR;
               else if (is_jalr)        state_nxt = S_JMP;
               else                     state_nxt = S_IF;
            end
            S_MEM: begin
               Size_s = func3[1:0];
               SE_s   = ~func3[2];
               if (is_st) begin
                  Mem_write  = 1'b1;
                  st         = store_mask(func3[1:0]);
                  instr_done = 1'b1;
                  state_nxt  = S_IF;
               end else begin
                  state_nxt = S_WB;
               end
            end
            S_WB: begin
               Size_s     = func3[1:0];
               SE_s       = ~func3[2];
               Reg_Write  = 1'b1;
               instr_done = 1'b1;
               if (is_ld)         w_data_s = WDS_MDR;
               else if (is_lui)   w_data_s = WDS_IMM;
               else if (is_auipc) w_data_s = WDS_PCIMM;
               else               w_data_s = WDS_F;
               state_nxt = S_IF;
            end
            S_BR: begin
               if (taken) begin
                  PC_Write = 1'b1;
                  PC_s     = PCS_IMM;
               end
               instr_done = 1'b1;
               state_nxt  = S_IF;
            end
            S_JMP: begin
               // PC still holds PC0+4 here, so rd captures the link address.
               Reg_Write  = 1'b1;
               w_data_s   = WDS_PC;
               PC_Write   = 1'b1;
               PC_s       = is_jalr ? PCS_F : PCS_IMM;
               instr_done = 1'b1;
               state_nxt  = S_IF;
            end
            S_HALT: begin
               halted    = 1'b1;
               state_nxt = S_HALT;
            end
            default: state_nxt = S_IF;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed scenarios plus random
// instruction streams compared cycle-by-cycle against a per-instruction
// trace model built from the instruction-level behaviour.
module tb_riscv_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       ZF, SF, CF, OF;
   logic [3:0] ALU_OP;
   logic       PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write;
   logic       SE_s;
   logic [1:0] Size_s, PC_s;
   logic       rs2_imm_s;
   logic [2:0] w_data_s;
   logic [3:0] st;
   logic       halted, instr_done;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       pc_write;
      logic       pc0_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       se_s;
      logic [1:0] size_s;
      logic [1:0] pc_s;
      logic       rs2_imm_s;
      logic [2:0] w_data_s;
      logic [3:0] st;
      logic       halted;
      logic       instr_done;
   } out_t;

   out_t act;
   out_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   assign act = {ALU_OP, PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write, SE_s,
                 Size_s, PC_s, rs2_imm_s, w_data_s, st, halted, instr_done};

   riscv_mc_ctrl dut (
      .clk        (clk),
      .rst_       (rst_),
      .opcode     (opcode),
      .func3      (func3),
      .func7      (func7),
      .ZF         (ZF),
      .SF         (SF),
      .CF         (CF),
      .OF         (OF),
      .ALU_OP     (ALU_OP),
      .PC_Write   (PC_Write),
      .PC0_Write  (PC0_Write),
      .IR_Write   (IR_Write),
      .Reg_Write  (Reg_Write),
      .Mem_write  (Mem_write),
      .SE_s       (SE_s),
      .Size_s     (Size_s),
      .PC_s       (PC_s),
      .rs2_imm_s  (rs2_imm_s),
      .w_data_s   (w_data_s),
      .st         (st),
      .halted     (halted),
      .instr_done (instr_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic bit model_taken(input logic [2:0] f3, input logic z, s, c, o);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return s != o;   // signed less-than
         3'd5:    return s == o;   // signed greater-or-equal
         3'd6:    return c;
         3'd7:    return !c;
         default: return 1'b0;
      endcase
   endfunction

   // Builds the expected per-cycle output sequence of one instruction.
   function automatic void build_trace(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic z, s, c, o,
                                       input int halt_cycles);
      out_t base, r;
      bit   r_t, i_t, ld, sto, br, jalr, jal, lui, auipc;
      r_t = (op == 7'h33); i_t = (op == 7'h13); ld = (op == 7'h03);
      sto = (op == 7'h23); br = (op == 7'h63); jalr = (op == 7'h67);
      jal = (op == 7'h6f); lui = (op == 7'h37); auipc = (op == 7'h17);
      base = '0;
      if (r_t)                   base.alu_op = {f7[5], f3};
      else if (i_t)              base.alu_op = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
      else if (br)               base.alu_op = 4'd8;
      base.rs2_imm_s = i_t | ld | sto | jalr;
      exp_q.delete();
      r = base; r.ir_write = 1; r.pc0_write = 1; r.pc_write = 1;
      exp_q.push_back(r);                                   // IF
      exp_q.push_back(base);                                // ID
      if (!(r_t | i_t | ld | sto | br | jalr | jal | lui | auipc)) begin
         r = base; r.halted = 1;
         for (int k = 0; k < halt_cycles; k++) exp_q.push_back(r);
         return;
      end
      if (!(jal | lui | auipc)) exp_q.push_back(base);      // EX
      r = base; r.size_s = f3[1:0]; r.se_s = !f3[2];
      if (ld) exp_q.push_back(r);                           // MEM (load)
      if (sto) begin
         r.mem_write = 1; r.instr_done = 1;
         r.st = (f3[1:0] == 0) ? 4'h1 : (f3[1:0] == 1) ? 4'h3 : 4'hf;
         exp_q.push_back(r);
      end else if (r_t | i_t | ld | lui | auipc) begin
         r.reg_write = 1; r.instr_done = 1;
         r.w_data_s = ld ? 3'd2 : lui ? 3'd1 : auipc ? 3'd4 : 3'd0;
         exp_q.push_back(r);                                // WB
      end else if (br) begin
         r = base; r.instr_done = 1;
         if (model_taken(f3, z, s, c, o)) begin r.pc_write = 1; r.pc_s = 2'd1; end
         exp_q.push_back(r);                                // BR
      end else begin
         r = base; r.reg_write = 1; r.w_data_s = 3'd3; r.pc_write = 1;
         r.pc_s = jalr ? 2'd2 : 2'd1; r.instr_done = 1;
         exp_q.push_back(r);                                // JMP
      end
   endfunction

   // ---------------- drivers / checkers ----------------
   // Entered just after a rising edge; leaves just after a rising edge.
   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic z, s, c, o,
                            input int halt_cycles, input int limit);
      int n;
      opcode = op; func3 = f3; func7 = f7; ZF = z; SF = s; CF = c; OF = o;
      build_trace(op, f3, f7, z, s, c, o, halt_cycles);
      n = (limit >= 0 && limit < exp_q.size()) ? limit : exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vectors++;
         if (act !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, i + 1, act, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input string name);
      rst_ = 1'b0;
      @(negedge clk);
      vectors++;
      if (act !== '0) begin
         miscompares++;
         $display("FAIL %s: outputs during reset got %h, expected 0", name, act);
      end
      @(posedge clk); #1;
      rst_ = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      opcode = 7'h33; func3 = 3'd5; func7 = 7'h20; {ZF, SF, CF, OF} = 4'hf;
      do_reset("reset_initial");
      do_reset("reset_repeat");
   endtask

   task automatic test_add();
      run_instr("add", 7'h33, 3'd0, 7'h00, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic test_lw();
      run_instr("lw", 7'h03, 3'd2, 7'h00, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic test_sb();
      run_instr("sb", 7'h23, 3'd0, 7'h00, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic test_blt();
      run_instr("blt_taken", 7'h63, 3'd4, 7'h00, 0, 1, 0, 0, 0, -1);
      run_instr("blt_not_taken", 7'h63, 3'd4, 7'h00, 0, 1, 0, 1, 0, -1);
   endtask

   task automatic test_jalr();
      run_instr("jalr", 7'h67, 3'd0, 7'h00, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic test_halt();
      run_instr("halt", 7'h7f, 3'd0, 7'h00, 0, 0, 0, 0, 20, -1);
      do_reset("halt_reset");
      run_instr("after_halt_add", 7'h33, 3'd0, 7'h20, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic test_mid_reset();
      run_instr("lw_aborted", 7'h03, 3'd1, 7'h00, 0, 0, 0, 0, 0, 3);
      do_reset("mid_reset");
      run_instr("after_abort_lui", 7'h37, 3'd3, 7'h11, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [9];
      logic [6:0] op;
      logic [2:0] f3;
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
      ops[5] = 7'h67; ops[6] = 7'h6f; ops[7] = 7'h37; ops[8] = 7'h17;
      for (int k = 0; k < 80; k++) begin
         op = ops[$urandom_range(0, 8)];
         f3 = 3'($urandom_range(0, 7));
         if (op == 7'h23) f3 = 3'($urandom_range(0, 2));
         run_instr("random", op, f3, 7'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 0, -1);
      end
   endtask

   initial begin
      rst_ = 1'b0;
      opcode = '0; func3 = '0; func7 = '0; {ZF, SF, CF, OF} = 4'h0;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_lw();
      test_sb();
      test_blt();
      test_jalr();
      test_halt();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 SHALL expose ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_  in  1  synchronous, active-low reset.
- opcode  in  7  decoded from IR.
- func3  in  3  decoded from IR.
- func7  in  7  decoded from IR.
- ZF, SF, CF, OF  in  1 each  registered ALU flags.
- ALU_OP  out  4  ALU operation.
- PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write  out  1 each  write enables.
- SE_s  out  1  load sign-extend.
- Size_s  out  2  access size.
- PC_s  out  2  next-PC select.
- rs2_imm_s  out  1  ALU B select.
- w_data_s  out  3  register write-data select.
- st  out  4  RAM byte write enables.
- halted  out  1  illegal-opcode stop flag.
- instr_done  out  1  one-cycle retire pulse.
REQ-002 Reset SHALL be synchronous and active-low; the design SHALL use one clock only.
REQ-003 Encodings SHALL be as follows:
- PC_s: 0=PC+4, 1=PC0+imm, 2=F.
- w_data_s: 0=F, 1=imm, 2=MDR, 3=PC, 4=PC0+imm.
- Size_s: 0=byte, 1=half, 2=word.

Function
REQ-004 Multi-cycle FSM states SHALL be IF, ID, EX, MEM, WB, BR, JMP, HALT.
REQ-005 IF SHALL assert IR_Write, PC0_Write and PC_Write with PC_s=0, then go to ID.
REQ-006 ID SHALL dispatch on opcode, with no write enables asserted:
- 0110011, 0010011, 0000011, 0100011, 1100011, 1100111 -> EX.
- 1101111 -> JMP.
- 0110111, 0010111 -> WB.
- any other value -> HALT.
REQ-007 ALU_OP SHALL be driven per instruction class:
- R-type: {func7[5], func3}.
- I-ALU: {func7[5], func3} when func3=101, else {0, func3}.
- LOAD, STORE, JALR: ADD (0000).
- BRANCH: SUB (1000).
REQ-008 rs2_imm_s SHALL be 1 for I-ALU, LOAD, STORE and JALR, and 0 otherwise.
REQ-009 EX SHALL transition as follows:
- R / I-ALU -> WB.
- LOAD / STORE -> MEM.
- BRANCH -> BR.
- JALR -> JMP.
REQ-010 MEM for STORE SHALL assert Mem_write for one cycle, then go to IF.
REQ-011 st SHALL be 0001 for byte, 0011 for half and 1111 for word stores, and 0000 whenever Mem_write=0.
REQ-012 MEM for LOAD SHALL assert no writes and SHALL go to WB.
REQ-013 Size_s SHALL equal func3[1:0] and SE_s SHALL equal ~func3[2] in MEM and WB.
REQ-014 WB SHALL assert Reg_Write for one cycle with the following w_data_s, then go to IF:
- R / I-ALU: 0.
- LOAD: 2.
- LUI: 1.
- AUIPC: 4.
REQ-015 BR SHALL compute taken from func3 and the flags:
- 000: ZF.
- 001: ~ZF.
- 100: SF^OF.
- 101: ~(SF^OF).
- 110: CF.
- 111: ~CF.
- 010 / 011: not taken.
REQ-016 In BR, if taken, the block SHALL assert PC_Write with PC_s=1; it SHALL then go to IF.
REQ-017 JMP SHALL assert Reg_Write with w_data_s=3 and PC_Write in the same cycle, then go to IF:
- JAL: PC_s=1.
- JALR: PC_s=2.
REQ-018 In the JMP cycle, rd SHALL receive the pre-update PC (PC0+4).
REQ-019 HALT SHALL hold all write enables at 0 and assert halted=1 until reset.
REQ-020 instr_done SHALL pulse in the final state of each instruction (WB, MEM-store, BR, JMP).
REQ-021 At most one of {Reg_Write, Mem_write} SHALL be asserted in any cycle.
REQ-022 IR_Write SHALL be asserted only in IF.
REQ-023 Latency SHALL be:
- LUI / AUIPC / JAL: 3 cycles.
- R / I-ALU / STORE / BRANCH / JALR: 4 cycles.
- LOAD: 5 cycles.

Reset
REQ-024 With rst_=0 at a rising edge, state SHALL become IF and halted SHALL clear.
REQ-025 During the reset cycle all enables, st and instr_done SHALL be 0 and all select outputs SHALL be 0.
REQ-026 Reset asserted mid-instruction SHALL abort that instruction without any further write, including from HALT.

Structure
REQ-027 Package riscv_mc_pkg SHALL hold the state enum, opcode constants, ALU_OP codes, and the PC_s, w_data_s and Size_s encodings.
REQ-028 One sub-module, branch_cond (func3 and flags -> taken), SHALL be used; all other logic SHALL be local to riscv_mc_ctrl.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- add (opcode 0110011, func3 000, func7 0) -> states IF,ID,EX,WB; Reg_Write=1 only in cycle 4 with w_data_s=0; ALU_OP=0000.
- lw (0000011, func3 010) -> IF,ID,EX,MEM,WB; Size_s=2, SE_s=1; WB w_data_s=2; instr_done in cycle 5.
- sb (0100011, func3 000) -> Mem_write=1 and st=0001 in cycle 4; Reg_Write never asserted.
- blt with SF=1, OF=0 -> PC_Write=1, PC_s=1 in BR; repeat with SF=OF=1 -> PC_Write=0 in BR.
- jalr (1100111) -> JMP cycle has Reg_Write=1, w_data_s=3, PC_Write=1, PC_s=2.
- opcode 1111111 -> HALT, halted=1, no enables for 20 cycles; rst_=0 one cycle -> IF, halted=0.
